// File: rtl/pipe_decode.sv
// pipe_decode: pipelined instruction-decode stage.
// Holds an NREG x WIDTH register file with a write-back port. It sign-extends
// the immediate and detects load-use hazards. Decoded operands and controls
// are latched into an ID/EX register that uses valid/ready handshakes on both
// sides.
// Optional macro WB_BYPASS_EN: a same-cycle write-back becomes visible to the
// operand reads (write-through). When the macro is undefined, a read returns
// the pre-write contents.
module pipe_decode #(
  parameter int  WIDTH = 32,
  parameter int  NREG  = 32,
  parameter int  IMM_W = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             regDst,
  input  logic             regWrite,
  input  logic             memRead,
  input  logic             memToReg,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rs_data,
  output logic [WIDTH-1:0] out_rt_data,
  output logic [WIDTH-1:0] out_imm,
  output logic [AW-1:0]    out_dest,
  output logic             out_regWrite,
  output logic             out_memRead,
  output logic             out_memToReg,
  output logic             stall
);

  logic [WIDTH-1:0] regs [NREG];
  logic [AW-1:0]    rs, rt, rd, dest;
  logic [WIDTH-1:0] rs_data, rt_data, imm;
  logic             hz, accept;
  logic             unused_instr;

  // Register-number fields; only the low AW bits of each field address the file.
  assign rs   = instr[21 +: AW];
  assign rt   = instr[16 +: AW];
  assign rd   = instr[11 +: AW];
  assign dest = regDst ? rd : rt;
  assign imm  = {{(WIDTH-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  // Opcode/funct bits are consumed by the control decoder, not by this stage.
  assign unused_instr = ^instr;

  // Write-back into the register file; register 0 is never written, so it stays 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Combinational operand reads, with optional write-through of the write-back port.
  always_comb begin
    rs_data = regs[rs];
    rt_data = regs[rt];
`ifdef WB_BYPASS_EN
    if (wb_en && (wb_addr != '0) && (wb_addr == rs)) rs_data = wb_data;
    if (wb_en && (wb_addr != '0) && (wb_addr == rt)) rt_data = wb_data;
`endif
    if (rs == '0) rs_data = '0;
    if (rt == '0) rt_data = '0;
  end

  // The input is blocked when the load in the ID/EX register feeds this instruction.
  assign hz       = in_valid & out_valid & out_memRead & (out_dest != '0) &
                    ((out_dest == rs) | (out_dest == rt));
  assign stall    = hz;
  assign in_ready = (~out_valid | out_ready) & ~hz;
  assign accept   = in_valid & in_ready;

  // ID/EX register: load on accept, drain to a bubble when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_imm      <= '0;
      out_dest     <= '0;
      out_regWrite <= 1'b0;
      out_memRead  <= 1'b0;
      out_memToReg <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs_data  <= rs_data;
      out_rt_data  <= rt_data;
      out_imm      <= imm;
      out_dest     <= dest;
      out_regWrite <= regWrite;
      out_memRead  <= memRead;
      out_memToReg <= memToReg;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: directed scenarios with literal expectations, followed by a
// randomized run. Both are checked every cycle against a behavioural model of
// the decode stage.
module tb_pipe_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        regDst, regWrite, memRead, memToReg;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
  logic [4:0]  out_dest;
  logic        out_regWrite, out_memRead, out_memToReg, stall;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  pipe_decode #(.WIDTH(32), .NREG(32), .IMM_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .regDst(regDst), .regWrite(regWrite), .memRead(memRead), .memToReg(memToReg),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_dest(out_dest), .out_regWrite(out_regWrite), .out_memRead(out_memRead),
    .out_memToReg(out_memToReg), .stall(stall)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        v;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  dest;
    logic        rw, mr, m2r;
  } idex_t;

  idex_t       m;
  logic [31:0] mregs [32];

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return mregs[a];
  endfunction

  function automatic logic model_hz();
    return in_valid && m.v && m.mr && (m.dest != 5'd0) &&
           (m.dest == instr[25:21] || m.dest == instr[20:16]);
  endfunction

  function automatic logic model_in_ready();
    return (!m.v || out_ready) && !model_hz();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= '{v: 1'b0, rs_d: 32'd0, rt_d: 32'd0, imm: 32'd0, dest: 5'd0,
             rw: 1'b0, mr: 1'b0, m2r: 1'b0};
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
    end else begin
      if (in_valid && model_in_ready()) begin
        m <= '{v: 1'b1,
               rs_d: model_read(instr[25:21]),
               rt_d: model_read(instr[20:16]),
               imm: 32'(signed'(instr[15:0])),
               dest: regDst ? instr[15:11] : instr[20:16],
               rw: regWrite, mr: memRead, m2r: memToReg};
      end else if (m.v && out_ready) begin
        m.v <= 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) mregs[wb_addr] <= wb_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid",    64'(out_valid),    64'(m.v));
      chk("out_rs_data",  64'(out_rs_data),  64'(m.rs_d));
      chk("out_rt_data",  64'(out_rt_data),  64'(m.rt_d));
      chk("out_imm",      64'(out_imm),      64'(m.imm));
      chk("out_dest",     64'(out_dest),     64'(m.dest));
      chk("out_regWrite", 64'(out_regWrite), 64'(m.rw));
      chk("out_memRead",  64'(out_memRead),  64'(m.mr));
      chk("out_memToReg", 64'(out_memToReg), 64'(m.m2r));
      chk("in_ready",     64'(in_ready),     64'(model_in_ready()));
      chk("stall",        64'(stall),        64'(model_hz()));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                     input logic [15:0] imm16);
    return {6'd0, rs_f, rt_f, imm16};
  endfunction

  task automatic drv(input logic v, input logic [31:0] ins, input logic rdst,
                     input logic rw, input logic mr, input logic m2r, input logic ordy,
                     input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    in_valid = v; instr = ins; regDst = rdst; regWrite = rw; memRead = mr;
    memToReg = m2r; out_ready = ordy; wb_en = wbe; wb_addr = wba; wb_data = wbd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [31:0] exp_byp;

  initial begin
`ifdef WB_BYPASS_EN
    exp_byp = 32'd7;
`else
    exp_byp = 32'd0;
`endif
    rst = 1'b0;
    drv(1, mk(5'd3, 5'd4, 16'h1234), 1, 1, 1, 1, 1, 1, 5'd2, 32'h55);
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    mid();
    chk("reset out_valid",   64'(out_valid),   64'd0);
    chk("reset out_rs_data", 64'(out_rs_data), 64'd0);
    chk("reset out_imm",     64'(out_imm),     64'd0);
    chk("reset out_memRead", 64'(out_memRead), 64'd0);
    step();
    rst = 1'b1;

    // read after reset returns 0
    drv(1, mk(5'd9, 5'd17, 16'h0), 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("post-reset out_valid", 64'(out_valid), 64'd1);
    chk("post-reset rs", 64'(out_rs_data), 64'd0);
    chk("post-reset rt", 64'(out_rt_data), 64'd0);
    step();

    // write then read
    drv(0, 32'd0, 0, 0, 0, 0, 1, 1, 5'd5, 32'hDEADBEEF); step();
    drv(1, mk(5'd5, 5'd0, 16'h1234), 0, 1, 0, 0, 1, 0, 5'd0, 32'd0); step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("wr-rd rs", 64'(out_rs_data), 64'h0000_0000_DEAD_BEEF);
    chk("wr-rd rt", 64'(out_rt_data), 64'd0);
    step();

    // sign extension
    drv(1, mk(5'd0, 5'd0, 16'h8001), 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); step();
    drv(1, mk(5'd0, 5'd0, 16'h7FFF), 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("imm neg", 64'(out_imm), 64'h0000_0000_FFFF_8001);
    step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("imm pos", 64'(out_imm), 64'h0000_0000_0000_7FFF);
    step();

    // load-use: one stall cycle, one bubble
    drv(1, mk(5'd1, 5'd8, 16'h0), 0, 1, 1, 1, 1, 0, 5'd0, 32'd0); step();
    drv(1, mk(5'd8, 5'd2, 16'h3000), 1, 1, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("lu stall", 64'(stall), 64'd1);
    chk("lu in_ready", 64'(in_ready), 64'd0);
    chk("lu load dest", 64'(out_dest), 64'd8);
    step(); mid();
    chk("lu bubble", 64'(out_valid), 64'd0);
    chk("lu stall released", 64'(stall), 64'd0);
    chk("lu accept", 64'(in_ready), 64'd1);
    step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("lu dep valid", 64'(out_valid), 64'd1);
    chk("lu dep dest", 64'(out_dest), 64'd6);
    step();

    // backpressure for 3 cycles
    drv(1, mk(5'd2, 5'd3, 16'h0042), 0, 1, 0, 0, 1, 0, 5'd0, 32'd0); step();
    drv(1, mk(5'd4, 5'd5, 16'h0099), 0, 1, 0, 0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp hold imm", 64'(out_imm), 64'h42);
      step();
    end
    out_ready = 1'b1; mid();
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("bp next imm", 64'(out_imm), 64'h99);
    step();

    // same-cycle write-back, r0 write ignored
    drv(1, mk(5'd3, 5'd0, 16'h0), 0, 0, 0, 0, 1, 1, 5'd3, 32'd7); step();
    drv(1, mk(5'd0, 5'd3, 16'h0), 0, 0, 0, 0, 1, 1, 5'd0, 32'hFFFF_FFFF); mid();
    chk("wb same-cycle rs", 64'(out_rs_data), 64'(exp_byp));
    step();
    drv(1, mk(5'd0, 5'd0, 16'h0), 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("r0 same-cycle", 64'(out_rs_data), 64'd0);
    chk("r3 next-cycle", 64'(out_rt_data), 64'd7);
    step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("r0 after write", 64'(out_rs_data), 64'd0);
    step();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 800; c++) begin
      drv(($urandom_range(0, 9) < 7),
          {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           16'($urandom)},
          1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3), 1'($urandom),
          ($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom_range(0, 7)),
          $urandom);
      step();
    end

    // reset mid-transfer discards the in-flight instruction and clears the file
    drv(1, mk(5'd5, 5'd3, 16'h1), 0, 1, 0, 0, 0, 0, 5'd0, 32'd0); step();
    rst = 1'b0;
    step(); mid();
    chk("mid-reset out_valid", 64'(out_valid), 64'd0);
    step();
    rst = 1'b1;
    drv(1, mk(5'd5, 5'd3, 16'h1), 0, 1, 0, 0, 1, 0, 5'd0, 32'd0); step();
    drv(0, 32'd0, 0, 0, 0, 0, 1, 0, 5'd0, 32'd0); mid();
    chk("after reset r5", 64'(out_rs_data), 64'd0);
    chk("after reset r3", 64'(out_rt_data), 64'd0);
    step();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
